// File: rtl/cdb_arbiter_if.sv
// Producer-side result ports and the CDB broadcast bundled for cdb_arbiter.
// The arbiter connects through the slave modport; the driving side uses master.
interface cdb_arbiter_if;
    logic        rdy_in;
    logic        clear;

    logic        alu_en;
    logic [4:0]  alu_rob;
    logic [31:0] alu_val;
    logic        alu_full;

    logic        lsb_en;
    logic [4:0]  lsb_rob;
    logic [31:0] lsb_val;
    logic        lsb_full;

    logic        br_en;
    logic [4:0]  br_rob;
    logic [31:0] br_val;
    logic        br_full;

    logic        cdb_en;
    logic [4:0]  cdb_rob;
    logic [31:0] cdb_val;

    modport master (
        output rdy_in, clear,
        output alu_en, alu_rob, alu_val,
        output lsb_en, lsb_rob, lsb_val,
        output br_en, br_rob, br_val,
        input  alu_full, lsb_full, br_full,
        input  cdb_en, cdb_rob, cdb_val
    );

    modport slave (
        input  rdy_in, clear,
        input  alu_en, alu_rob, alu_val,
        input  lsb_en, lsb_rob, lsb_val,
        input  br_en, br_rob, br_val,
        output alu_full, lsb_full, br_full,
        output cdb_en, cdb_rob, cdb_val
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: three per-producer FIFOs (ALU, LSB, BR) drained one
// entry per cycle onto a registered broadcast bus using round-robin priority.
module cdb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    cdb_arbiter_if.slave bus
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned NSRC = 3;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LSB = 2'd1,
        SRC_BR  = 2'd2
    } src_t;

    logic [NSRC-1:0] push_req;
    logic [4:0]      in_rob [NSRC];
    logic [31:0]     in_val [NSRC];

    logic [36:0]     mem   [NSRC][DEPTH];
    logic [AW-1:0]   head  [NSRC];
    logic [AW-1:0]   tail  [NSRC];
    logic [AW:0]     count [NSRC];

    logic [NSRC-1:0] full;
    logic [NSRC-1:0] elig;
    logic [NSRC-1:0] push;
    logic [NSRC-1:0] pop;
    logic            advance;

    src_t            rr;
    src_t            rr_next;
    src_t            grant_src;
    logic            grant_vld;
    logic [36:0]     grant_entry;
    int unsigned     cand;

    logic            cdb_en_q;
    logic [4:0]      cdb_rob_q;
    logic [31:0]     cdb_val_q;

    assign push_req  = {bus.br_en, bus.lsb_en, bus.alu_en};
    assign in_rob[0] = bus.alu_rob;
    assign in_rob[1] = bus.lsb_rob;
    assign in_rob[2] = bus.br_rob;
    assign in_val[0] = bus.alu_val;
    assign in_val[1] = bus.lsb_val;
    assign in_val[2] = bus.br_val;

    // State only moves on an enabled cycle that is not being reset or flushed.
    assign advance = bus.rdy_in && !rst_in && !bus.clear;

    always_comb begin
        full = '0;
        elig = '0;
        push = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            full[i] = (count[i] == (AW+1)'(DEPTH));
            elig[i] = (count[i] != '0);
            push[i] = push_req[i] && !full[i] && advance;
        end
    end

    // Eligibility uses the start-of-cycle count, so a same-cycle push is never granted.
    always_comb begin
        grant_vld = 1'b0;
        grant_src = SRC_ALU;
        cand      = 0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            cand = (32'(rr) + k) % NSRC;
            if (!grant_vld && elig[cand]) begin
                grant_vld = 1'b1;
                grant_src = src_t'(cand[1:0]);
            end
        end
        grant_entry = mem[grant_src][head[grant_src]];
        pop = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            pop[i] = grant_vld && advance && (grant_src == src_t'(i[1:0]));
        end
        case (grant_src)
            SRC_ALU: rr_next = SRC_LSB;
            SRC_LSB: rr_next = SRC_BR;
            default: rr_next = SRC_ALU;
        endcase
    end

    always_ff @(posedge clk_in) begin
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (push[i]) begin
                mem[i][tail[i]] <= {in_rob[i], in_val[i]};
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || bus.clear) begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
            rr        <= SRC_ALU;
            cdb_en_q  <= 1'b0;
            cdb_rob_q <= '0;
            cdb_val_q <= '0;
        end else if (bus.rdy_in) begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                if (push[i]) begin
                    tail[i] <= tail[i] + AW'(1);
                end
                if (pop[i]) begin
                    head[i] <= head[i] + AW'(1);
                end
                count[i] <= count[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
            end
            if (grant_vld) begin
                cdb_en_q  <= 1'b1;
                cdb_rob_q <= grant_entry[36:32];
                cdb_val_q <= grant_entry[31:0];
                rr        <= rr_next;
            end else begin
                cdb_en_q  <= 1'b0;
            end
        end
    end

    assign bus.alu_full = full[0];
    assign bus.lsb_full = full[1];
    assign bus.br_full  = full[2];
    assign bus.cdb_en   = cdb_en_q;
    assign bus.cdb_rob  = cdb_rob_q;
    assign bus.cdb_val  = cdb_val_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter with DEPTH=2.
module tb_cdb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    cdb_arbiter_if bus ();

    cdb_arbiter #(.DEPTH(2)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic l, input logic b,
                         input logic [4:0] ra, input logic [4:0] rl, input logic [4:0] rb);
        bus.alu_en  = a;
        bus.alu_rob = ra;
        bus.alu_val = 32'h1000 + 32'(ra);
        bus.lsb_en  = l;
        bus.lsb_rob = rl;
        bus.lsb_val = 32'h1000 + 32'(rl);
        bus.br_en   = b;
        bus.br_rob  = rb;
        bus.br_val  = 32'h1000 + 32'(rb);
    endtask

    task automatic do_reset;
        bus.rdy_in = 1'b1;
        bus.clear  = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        total++; if (bus.cdb_en !== 1'b0) begin bad++; $display("FAIL rst_en: got %b want 0", bus.cdb_en); end
        total++; if (bus.cdb_rob !== 5'd0) begin bad++; $display("FAIL rst_rob: got %0d want 0", bus.cdb_rob); end
        total++; if (bus.cdb_val !== 32'd0) begin bad++; $display("FAIL rst_val: got %h want 0", bus.cdb_val); end
        total++; if ({bus.alu_full, bus.lsb_full, bus.br_full} !== 3'b000) begin
            bad++; $display("FAIL rst_full: got %b want 000", {bus.alu_full, bus.lsb_full, bus.br_full});
        end
    endtask

    task automatic test_latency;
        do_reset;
        drive(1, 0, 0, 3, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        total++; if (bus.cdb_en !== 1'b0) begin bad++; $display("FAIL lat_bypass: got %b want 0", bus.cdb_en); end
        tick;
        total++; if (bus.cdb_en !== 1'b1) begin bad++; $display("FAIL lat_en: got %b want 1", bus.cdb_en); end
        total++; if (bus.cdb_rob !== 5'd3) begin bad++; $display("FAIL lat_rob: got %0d want 3", bus.cdb_rob); end
        total++; if (bus.cdb_val !== 32'h1003) begin bad++; $display("FAIL lat_val: got %h want 00001003", bus.cdb_val); end
        tick;
        total++; if (bus.cdb_en !== 1'b0) begin bad++; $display("FAIL lat_pulse: got %b want 0", bus.cdb_en); end
    endtask

    task automatic test_round_robin;
        logic [4:0] exp_rob [3];
        exp_rob[0] = 5'd1; exp_rob[1] = 5'd2; exp_rob[2] = 5'd3;
        do_reset;
        drive(1, 1, 1, 1, 2, 3);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            total++;
            if (bus.cdb_en !== 1'b1 || bus.cdb_rob !== exp_rob[i] || bus.cdb_val !== 32'h1000 + 32'(exp_rob[i])) begin
                bad++;
                $display("FAIL rr_order[%0d]: got en=%b rob=%0d val=%h want en=1 rob=%0d", i, bus.cdb_en, bus.cdb_rob, bus.cdb_val, exp_rob[i]);
            end
        end
        tick;
        total++; if (bus.cdb_en !== 1'b0) begin bad++; $display("FAIL rr_idle: got %b want 0", bus.cdb_en); end
        // rr back at ALU: ALU must beat BR
        drive(1, 0, 1, 12, 0, 14);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        tick;
        total++; if (bus.cdb_rob !== 5'd12 || bus.cdb_en !== 1'b1) begin bad++; $display("FAIL rr_wrap_first: got en=%b rob=%0d want en=1 rob=12", bus.cdb_en, bus.cdb_rob); end
        tick;
        total++; if (bus.cdb_rob !== 5'd14 || bus.cdb_en !== 1'b1) begin bad++; $display("FAIL rr_wrap_second: got en=%b rob=%0d want en=1 rob=14", bus.cdb_en, bus.cdb_rob); end
    endtask

    task automatic test_starvation;
        logic [4:0] alu_next;
        logic [4:0] seen [3];
        logic [4:0] exp_rob [3];
        exp_rob[0] = 5'd10; exp_rob[1] = 5'd20; exp_rob[2] = 5'd11;
        do_reset;
        drive(1, 1, 0, 10, 20, 0);
        tick;
        alu_next = 5'd11;
        for (int i = 0; i < 3; i++) begin
            drive(!bus.alu_full, 0, 0, alu_next, 0, 0);
            tick;
            if (bus.alu_en) alu_next = alu_next + 5'd1;
            seen[i] = bus.cdb_en ? bus.cdb_rob : 5'd31;
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (seen[i] !== exp_rob[i]) begin bad++; $display("FAIL starve[%0d]: got rob=%0d want %0d", i, seen[i], exp_rob[i]); end
        end
        total++; if (bus.alu_full !== 1'b0) begin bad++; $display("FAIL starve_full: got %b want 0", bus.alu_full); end
    endtask

    task automatic test_full_drop;
        logic [4:0] q[$];
        int br_cnt;
        do_reset;
        drive(1, 1, 1, 4, 5, 6);
        tick;
        drive(0, 0, 1, 0, 0, 7);
        tick;
        if (bus.cdb_en) q.push_back(bus.cdb_rob);
        total++; if (bus.br_full !== 1'b1) begin bad++; $display("FAIL full_set: got %b want 1", bus.br_full); end
        drive(0, 0, 1, 0, 0, 8);
        tick;
        if (bus.cdb_en) q.push_back(bus.cdb_rob);
        total++; if (bus.br_full !== 1'b1) begin bad++; $display("FAIL full_hold: got %b want 1", bus.br_full); end
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick;
            if (bus.cdb_en) q.push_back(bus.cdb_rob);
        end
        br_cnt = 0;
        foreach (q[i]) if (q[i] >= 5'd6) br_cnt++;
        total++; if (br_cnt !== 2) begin bad++; $display("FAIL full_br_count: got %0d want 2", br_cnt); end
        total++;
        if (q.size() !== 4 || q[0] !== 5'd4 || q[1] !== 5'd5 || q[2] !== 5'd6 || q[3] !== 5'd7) begin
            bad++; $display("FAIL full_seq: got size=%0d seq=%p want 4,5,6,7", q.size(), q);
        end
        total++; if (bus.br_full !== 1'b0) begin bad++; $display("FAIL full_clear: got %b want 0", bus.br_full); end
    endtask

    task automatic test_clear;
        int stale;
        do_reset;
        drive(1, 1, 1, 1, 2, 3);
        tick;
        drive(1, 1, 1, 4, 5, 6);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        total++; if ({bus.alu_full, bus.lsb_full, bus.br_full} !== 3'b011) begin
            bad++; $display("FAIL clr_pre_full: got %b want 011", {bus.alu_full, bus.lsb_full, bus.br_full});
        end
        bus.clear = 1'b1;
        tick;
        bus.clear = 1'b0;
        total++; if (bus.cdb_en !== 1'b0) begin bad++; $display("FAIL clr_en: got %b want 0", bus.cdb_en); end
        total++; if ({bus.alu_full, bus.lsb_full, bus.br_full} !== 3'b000) begin
            bad++; $display("FAIL clr_full: got %b want 000", {bus.alu_full, bus.lsb_full, bus.br_full});
        end
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (bus.cdb_en !== 1'b0) stale++;
        end
        total++; if (stale !== 0) begin bad++; $display("FAIL clr_stale: got %0d broadcasts want 0", stale); end
    endtask

    task automatic test_rdy_freeze;
        int moved;
        do_reset;
        drive(1, 1, 1, 9, 10, 11);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        tick;
        total++; if (bus.cdb_en !== 1'b1 || bus.cdb_rob !== 5'd9) begin bad++; $display("FAIL rdy_pre: got en=%b rob=%0d want en=1 rob=9", bus.cdb_en, bus.cdb_rob); end
        bus.rdy_in = 1'b0;
        drive(1, 0, 0, 30, 0, 0);
        moved = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (bus.cdb_en !== 1'b1 || bus.cdb_rob !== 5'd9 || bus.cdb_val !== 32'h1009) moved++;
        end
        total++; if (moved !== 0) begin bad++; $display("FAIL rdy_frozen: got %0d changed cycles want 0", moved); end
        bus.rdy_in = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        tick;
        total++; if (bus.cdb_en !== 1'b1 || bus.cdb_rob !== 5'd10) begin bad++; $display("FAIL rdy_resume1: got en=%b rob=%0d want en=1 rob=10", bus.cdb_en, bus.cdb_rob); end
        tick;
        total++; if (bus.cdb_en !== 1'b1 || bus.cdb_rob !== 5'd11) begin bad++; $display("FAIL rdy_resume2: got en=%b rob=%0d want en=1 rob=11", bus.cdb_en, bus.cdb_rob); end
        tick;
        total++; if (bus.cdb_en !== 1'b0) begin bad++; $display("FAIL rdy_no_dup: got en=%b rob=%0d want en=0", bus.cdb_en, bus.cdb_rob); end
    endtask

    initial begin
        bus.rdy_in = 1'b1;
        bus.clear  = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        test_reset;
        test_latency;
        test_round_robin;
        test_starvation;
        test_full_drop;
        test_clear;
        test_rdy_freeze;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
